// File: rtl/conv_out_collector.sv
// Collects a raster of convolution results, saturates them to 8 bits and writes them to a frame buffer.
// Optional: define CONV_COLLECT_ABS_EN to map negative samples to |pxl_in| instead of 0.
module conv_out_collector #(
   parameter int IMG_W = 220,
   parameter int K     = 5,
   parameter int SHIFT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic signed [15:0] pxl_in,
   input  logic               valid,
   output logic               wr_en,
   output logic        [15:0] wr_addr,
   output logic        [7:0]  wr_data,
   output logic        [7:0]  row,
   output logic        [7:0]  col,
   output logic               busy,
   output logic               frame_done,
   output logic               overflow
);

   localparam int OUT_W = IMG_W - K + 1;
   localparam int OUT_N = OUT_W * OUT_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_count;
   logic        w_accept;
   logic        w_last;
   logic [16:0] w_sext;
   logic [16:0] w_mag;
   logic [16:0] w_shift;
   logic [7:0]  w_sat;

   assign w_accept = (r_state == S_COLLECT) && valid;
   assign w_last   = w_accept && (r_count == 16'(OUT_N - 1));
   assign busy     = (r_state == S_COLLECT);

   // 17 bits so that -32768 becomes +32768 without wrapping.
   assign w_sext = {pxl_in[15], pxl_in};
`ifdef CONV_COLLECT_ABS_EN
   assign w_mag = pxl_in[15] ? (~w_sext + 17'd1) : w_sext;
`else
   assign w_mag = pxl_in[15] ? 17'd0 : w_sext;
`endif
   assign w_shift = w_mag >> SHIFT;
   assign w_sat   = (w_shift > 17'd255) ? 8'hFF : w_shift[7:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets its default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (start) w_next = S_COLLECT;
         S_COLLECT: if (w_last) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         row        <= '0;
         col        <= '0;
         r_count    <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         wr_en      <= w_accept;
         frame_done <= (r_state == S_DONE);

         if ((r_state == S_IDLE) && start) begin
            row      <= '0;
            col      <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
         end else if (valid && (r_state != S_COLLECT)) begin
            overflow <= 1'b1;
         end

         if (w_accept) begin
            wr_addr <= r_count;
            wr_data <= w_sat;
            r_count <= r_count + 16'd1;
            if (col == 8'(OUT_W - 1)) begin
               col <= '0;
               row <= row + 8'd1;
            end else begin
               col <= col + 8'd1;
            end
         end
      end
   end

endmodule
